// File: rtl/cnr_atr_trim_pkg.sv
// Shared types and constants for the SAR trim controller.
package cnr_atr_trim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam int VOTE_N = 3;

  function automatic logic [31:0] msb_onehot(input int nbits);
    return 32'd1 << (nbits - 1);
  endfunction

endpackage

// File: rtl/cnr_atr_trim_sar_cmp_vote.sv
// Comparator majority voter: two held samples plus the live one.
// Only instantiated when CNR_ATR_TRIM_VOTE_EN is defined.
module cnr_atr_cmp_vote (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic cmp,
  output logic maj
);

  logic [1:0] hist_q;
  logic [2:0] win;

  assign win = {hist_q, cmp};

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b00;
    end else if (shift_en) begin
      hist_q <= win[1:0];
    end
  end

  assign maj = (win[2] & win[1]) | (win[2] & win[0]) | (win[1] & win[0]);

endmodule

// File: rtl/cnr_atr_trim_sar_ctrl.sv
// Successive-approximation trim controller driving a PCH/NCH leg bank.
// Define CNR_ATR_TRIM_VOTE_EN for a 3-sample majority decision per bit.
//
// state  | meaning
// IDLE   | hold code; manual override or wait for START
// SETTLE | trial code applied, settle counter running
// SAMPLE | capture comparator decision for bit idx
// FIN    | one-cycle DONE, result held
module cnr_atr_trim_sar_ctrl
  import cnr_atr_trim_pkg::*;
#(
  parameter int               NBITS      = 5,
  parameter int               SETTLE_CYC = 8,
  parameter logic [NBITS-1:0] RST_CODE   = NBITS'(msb_onehot(NBITS))
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CMP,
  input  logic             MAN_EN,
  input  logic [NBITS-1:0] MAN_CODE,
  output logic [NBITS-1:0] CODE,
  output logic [NBITS-1:0] EN_P,
  output logic [NBITS-1:0] EN_N,
  output logic             BUSY,
  output logic             DONE
);

  localparam int               CW       = $clog2(SETTLE_CYC + 1);
  localparam int               IW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0]    IDX_MSB  = IW'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_CODE = NBITS'(msb_onehot(NBITS));

  state_t           state_q, state_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [IW-1:0]    idx_q, idx_d, idx_m1;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             decision;
  logic             sample_last;

`ifdef CNR_ATR_TRIM_VOTE_EN
  logic [1:0] vcnt_q, vcnt_d;

  cnr_atr_cmp_vote u_vote (
    .clk      (CLK),
    .rst      (RST),
    .shift_en (state_q == SAMPLE),
    .cmp      (CMP),
    .maj      (decision)
  );

  assign sample_last = (vcnt_q == 2'(VOTE_N - 1));
`else
  assign decision    = CMP;
  assign sample_last = 1'b1;
`endif

  assign idx_m1 = idx_q - IW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      code_q  <= RST_CODE;
      idx_q   <= IDX_MSB;
      cnt_q   <= CNT_LOAD;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef CNR_ATR_TRIM_VOTE_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      vcnt_q <= 2'd0;
    end else begin
      vcnt_q <= vcnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
`ifdef CNR_ATR_TRIM_VOTE_EN
    vcnt_d  = vcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (MAN_EN) begin
          code_d = MAN_CODE;
        end else if (START) begin
          code_d  = MSB_CODE;
          idx_d   = IDX_MSB;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SAMPLE: begin
`ifdef CNR_ATR_TRIM_VOTE_EN
        vcnt_d = sample_last ? 2'd0 : vcnt_q + 2'd1;
`endif
        if (sample_last) begin
          if (!decision) code_d[idx_q] = 1'b0;
          if (idx_q != '0) begin
            code_d[idx_m1] = 1'b1;
            idx_d          = idx_m1;
            cnt_d          = CNT_LOAD;
            state_d        = SETTLE;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers; EN_N is only an inversion of CODE.
  assign CODE = code_q;
  assign EN_P = code_q;
  assign EN_N = ~code_q;
  assign BUSY = busy_q;
  assign DONE = (state_q == FIN);

endmodule
